// File: rtl/bin_pool_channel_sequencer_pkg.sv
// Shared geometry constants and state encoding for the layer-2 binary max-pool sequencer.
// The constants give the default 11x11 geometry. The helper functions recompute
// the same constants for any parameterised instance.
package bin_pool_channel_sequencer_pkg;

  localparam int IN_WIDTH   = 11;
  localparam int IN_HEIGHT  = 11;
  localparam int OUT_W      = IN_WIDTH / 2;
  localparam int OUT_H      = IN_HEIGHT / 2;
  localparam int OUT_PER_CH = OUT_W * OUT_H;
  localparam int IN_PER_CH  = IN_WIDTH * IN_HEIGHT;

  // Pooled bits per channel; odd trailing rows and columns are dropped.
  function automatic int out_per_ch(input int w, input int h);
    return (w / 2) * (h / 2);
  endfunction

  // Input pixels per channel.
  function automatic int in_per_ch(input int w, input int h);
    return w * h;
  endfunction

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/bin_pool_channel_sequencer_raster_counter.sv
// Raster scan generator: walks col 0..W-1 within row 0..H-1 on each enable.
// It produces base + row*W + col combinationally and flags the final pixel.
// The clear input, or reset, returns the scan to pixel (0,0).
module bin_pool_raster_counter #(
  parameter int W      = 11,
  parameter int H      = 11,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int COL_W = (W > 1) ? $clog2(W) : 1;
  localparam int ROW_W = (H > 1) ? $clog2(H) : 1;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_end;
  logic             row_end;

  // End-of-line / end-of-frame detection and linear address
  always_comb begin
    col_end = (col == COL_W'(W - 1));
    row_end = (row == ROW_W'(H - 1));
    last    = col_end && row_end;
    addr    = base + ADDR_W'(row) * ADDR_W'(W) + ADDR_W'(col);
  end

  // Advance the scan one pixel per enable; col wraps and carries into row
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bin_pool_channel_sequencer.sv
// Per-channel sequencer for the layer-2 binary 2x2 max pool.
// For each channel it clears the pool, rasters the bitmap from activation memory,
// and writes the pooled bits to output memory. A single start pulse runs all channels.
module bin_pool_channel_sequencer
  import bin_pool_channel_sequencer_pkg::*;
#(
  parameter int IN_WIDTH  = 11,
  parameter int IN_HEIGHT = 11,
  parameter int MAX_CH    = 32,
  parameter int CH_W      = 6,
  parameter int RD_ADDR_W = 12,
  parameter int WR_ADDR_W = 10,
  parameter int DRAIN_MAX = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CH_W-1:0]      num_ch,
  input  logic                 hold,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 rd_en,
  output logic [RD_ADDR_W-1:0] rd_addr,
  input  logic                 rd_data,
  output logic                 pool_rst,
  output logic                 pool_valid_in,
  output logic                 pool_pixel_in,
  input  logic                 pool_valid_out,
  input  logic                 pool_pixel_out,
  output logic                 wr_en,
  output logic [WR_ADDR_W-1:0] wr_addr,
  output logic                 wr_data
);

  localparam int OPC  = out_per_ch(IN_WIDTH, IN_HEIGHT);
  localparam int IPC  = in_per_ch(IN_WIDTH, IN_HEIGHT);
  localparam int OC_W = $clog2(OPC + 1);
  localparam int DC_W = $clog2(DRAIN_MAX + 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [CH_W-1:0]        ch_q;
  logic [CH_W-1:0]        ch_next;
  logic [CH_W-1:0]        num_ch_q;
  logic [CH_W-1:0]        num_ch_sat;
  logic                   clr_cnt_q;
  logic [OC_W-1:0]        out_count_q;
  logic [DC_W-1:0]        drain_cnt_q;
  logic                   err_q;
  logic                   pool_valid_q;
  logic                   wr_en_q;
  logic [WR_ADDR_W-1:0]   wr_addr_q;
  logic                   wr_data_q;
  logic [RD_ADDR_W-1:0]   rd_base;
  logic                   rd_last;
  logic                   collect;
  logic                   out_full;
  logic                   drain_complete;
  logic                   drain_timeout;
  logic                   drain_exit;

  // Channel base address, channel-advance and drain exit conditions
  always_comb begin
    num_ch_sat     = (num_ch > CH_W'(MAX_CH)) ? CH_W'(MAX_CH) : num_ch;
    ch_next        = ch_q + 1'b1;
    rd_base        = RD_ADDR_W'(ch_q) * RD_ADDR_W'(IPC);
    collect        = (state_q == STREAM) || (state_q == DRAIN) || (state_q == DONE);
    out_full       = (out_count_q == OC_W'(OPC));
    drain_complete = out_full && !wr_en_q;
    drain_timeout  = (drain_cnt_q == DC_W'(DRAIN_MAX - 1));
    drain_exit     = drain_complete || drain_timeout;
  end

  bin_pool_raster_counter #(
    .W      (IN_WIDTH),
    .H      (IN_HEIGHT),
    .ADDR_W (RD_ADDR_W)
  ) u_rd_raster (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == CLEAR),
    .en    (rd_en),
    .base  (rd_base),
    .addr  (rd_addr),
    .last  (rd_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_ch_sat == '0) ? DONE : CLEAR;
      CLEAR:   if (clr_cnt_q) state_d = STREAM;
      STREAM:  if (rd_en && rd_last) state_d = DRAIN;
      DRAIN:   if (drain_exit) state_d = (ch_next < num_ch_q) ? CLEAR : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; hold only gates reads while streaming
  always_comb begin
    busy     = (state_q != IDLE);
    pool_rst = (state_q == CLEAR);
    done     = (state_q == DONE);
    rd_en    = (state_q == STREAM) && !hold;
  end

  // Channel/clear/drain bookkeeping, pool feed delay, output write port and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q         <= '0;
      num_ch_q     <= '0;
      clr_cnt_q    <= 1'b0;
      out_count_q  <= '0;
      drain_cnt_q  <= '0;
      err_q        <= 1'b0;
      pool_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 1'b0;
    end else begin
      pool_valid_q <= rd_en;
      wr_en_q      <= 1'b0;

      if (state_q == IDLE && start) begin
        num_ch_q <= num_ch_sat;
        ch_q     <= '0;
        err_q    <= 1'b0;
      end

      if (state_q == CLEAR) begin
        clr_cnt_q   <= ~clr_cnt_q;
        out_count_q <= '0;
      end else begin
        clr_cnt_q <= 1'b0;
      end

      drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + 1'b1 : '0;

      if (collect && pool_valid_out) begin
        if (!out_full) begin
          wr_en_q     <= 1'b1;
          wr_addr_q   <= WR_ADDR_W'(ch_q) * WR_ADDR_W'(OPC) + WR_ADDR_W'(out_count_q);
          wr_data_q   <= pool_pixel_out;
          out_count_q <= out_count_q + 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end

      if (state_q == DRAIN && drain_exit) begin
        ch_q <= ch_next;
        if (!drain_complete) err_q <= 1'b1;
      end
    end
  end

  // The delayed valid also masks rd_data, so the pixel is quiet between reads
  always_comb begin
    pool_valid_in = pool_valid_q;
    pool_pixel_in = pool_valid_q & rd_data;
    err           = err_q;
    wr_en         = wr_en_q;
    wr_addr       = wr_addr_q;
    wr_data       = wr_data_q;
  end

endmodule

// File: tb/tb_bin_pool_channel_sequencer.sv
// Directed bench for bin_pool_channel_sequencer.
// It uses a behavioural activation memory and a behavioural 2x2 OR-pool
// with one cycle of latency. The monitor collects per-run statistics on the falling edge.
module tb_bin_pool_channel_sequencer;
  import bin_pool_channel_sequencer_pkg::*;

  localparam int CH_W      = 6;
  localparam int RD_ADDR_W = 12;
  localparam int WR_ADDR_W = 10;
  localparam int DRAIN_MAX = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [CH_W-1:0]      num_ch;
  logic                 hold;
  logic                 busy, done, err;
  logic                 rd_en;
  logic [RD_ADDR_W-1:0] rd_addr;
  logic                 rd_data;
  logic                 pool_rst, pool_valid_in, pool_pixel_in;
  logic                 pool_valid_out, pool_pixel_out;
  logic                 wr_en;
  logic [WR_ADDR_W-1:0] wr_addr;
  logic                 wr_data;

  always #5 clk = ~clk;

  bin_pool_channel_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .num_ch(num_ch), .hold(hold),
    .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .pool_rst(pool_rst), .pool_valid_in(pool_valid_in),
    .pool_pixel_in(pool_pixel_in), .pool_valid_out(pool_valid_out),
    .pool_pixel_out(pool_pixel_out), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  int total = 0;
  int bad   = 0;

  bit mem    [0:4095];
  bit exp_wr [0:127];
  bit drop_last;
  bit clr_stats;

  // activation memory: one-cycle read latency
  always @(posedge clk) begin
    if (reset)      rd_data <= 1'b0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

  // behavioural 2x2 OR-pool, cleared by system reset or pool_rst
  int pc, pr, pidx;
  bit hp;
  bit lb [0:OUT_W-1];
  always @(posedge clk) begin : pool_model
    bit h;
    pool_valid_out <= 1'b0;
    pool_pixel_out <= 1'b0;
    if (reset || pool_rst) begin
      pc <= 0; pr <= 0; pidx <= 0; hp <= 1'b0;
    end else if (pool_valid_in) begin
      h = (pc % 2 == 0) ? pool_pixel_in : (hp | pool_pixel_in);
      hp <= h;
      if ((pc % 2 == 1) && (pc / 2 < OUT_W)) begin
        if (pr % 2 == 0) lb[pc/2] <= h;
        else if (pr / 2 < OUT_H) begin
          if (!(drop_last && pidx == OUT_PER_CH - 1)) begin
            pool_valid_out <= 1'b1;
            pool_pixel_out <= lb[pc/2] | h;
          end
          pidx <= pidx + 1;
        end
      end
      if (pc == IN_WIDTH - 1) begin pc <= 0; pr <= pr + 1; end
      else pc <= pc + 1;
    end
  end

  // run statistics, sampled mid-cycle
  int cyc, rd_cnt, rd_bad, wr_cnt, wr_bad, prst_cyc, prst_pulses, done_cnt, busy_cyc;
  int idle_run, max_gap, last_rd_cyc, done_cyc;
  bit prst_prev;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (clr_stats) begin
      rd_cnt <= 0; rd_bad <= 0; wr_cnt <= 0; wr_bad <= 0; prst_cyc <= 0;
      prst_pulses <= 0; done_cnt <= 0; busy_cyc <= 0; idle_run <= 0;
      max_gap <= 0; last_rd_cyc <= 0; done_cyc <= 0; prst_prev <= 1'b0;
    end else begin
      if (rd_en) begin
        if (rd_addr !== RD_ADDR_W'(rd_cnt)) rd_bad <= rd_bad + 1;
        rd_cnt      <= rd_cnt + 1;
        last_rd_cyc <= cyc;
        if (rd_cnt > 0 && idle_run > max_gap) max_gap <= idle_run;
        idle_run <= 0;
      end else if (rd_cnt > 0) begin
        idle_run <= idle_run + 1;
      end
      if (wr_en) begin
        if (wr_addr !== WR_ADDR_W'(wr_cnt) || wr_cnt > 127 || wr_data !== exp_wr[wr_cnt & 127])
          wr_bad <= wr_bad + 1;
        wr_cnt <= wr_cnt + 1;
      end
      if (pool_rst) prst_cyc <= prst_cyc + 1;
      if (pool_rst && !prst_prev) prst_pulses <= prst_pulses + 1;
      prst_prev <= pool_rst;
      if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
      if (busy) busy_cyc <= busy_cyc + 1;
    end
  end

  task automatic reset_stats();
    @(negedge clk); #1 clr_stats = 1'b1;
    @(negedge clk); #1 clr_stats = 1'b0;
  endtask

  // mode 0: all ones; mode 1: only pixel (1,1) of each channel set
  task automatic fill_mem(input int mode);
    for (int i = 0; i < 4096; i++)
      mem[i] = (mode == 0) ? 1'b1 : (((i % IN_PER_CH) / IN_WIDTH == 1) && ((i % IN_PER_CH) % IN_WIDTH == 1));
  endtask

  task automatic set_exp(input int mode);
    for (int i = 0; i < 128; i++) exp_wr[i] = (mode == 0) ? 1'b1 : (i % OUT_PER_CH == 0);
  endtask

  task automatic do_run(input int n, input bit spurious, input int budget, output bit timed_out);
    @(negedge clk); start = 1'b1; num_ch = n[CH_W-1:0];
    @(negedge clk); start = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (spurious && i == 20) begin start = 1'b1; num_ch = 6'd3; end
      if (spurious && i == 21) start = 1'b0;
      if (done_cnt > 0) begin timed_out = 1'b0; break; end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic hold_pulse();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (rd_cnt >= 41) break;
    end
    @(posedge clk); #1 hold = 1'b1;
    repeat (10) @(posedge clk);
    #1 hold = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; num_ch = '0; hold = 1'b0; drop_last = 1'b0; clr_stats = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, err, rd_en, pool_rst, pool_valid_in, pool_pixel_in, wr_en, wr_data} !== 9'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000000000",
               {busy, done, err, rd_en, pool_rst, pool_valid_in, pool_pixel_in, wr_en, wr_data});
    end
    total++;
    if (rd_addr !== '0 || wr_addr !== '0) begin
      bad++;
      $display("FAIL reset_addr: got rd=%0d wr=%0d want 0/0", rd_addr, wr_addr);
    end
    @(negedge clk); #1 reset = 1'b0;
  endtask

  task automatic check_single(input string tag, input int gap);
    check_int({tag, "_rd_cnt"}, rd_cnt, IN_PER_CH);
    check_int({tag, "_rd_addr_bad"}, rd_bad, 0);
    check_int({tag, "_pool_rst_cycles"}, prst_cyc, 2);
    check_int({tag, "_wr_cnt"}, wr_cnt, OUT_PER_CH);
    check_int({tag, "_wr_bad"}, wr_bad, 0);
    check_int({tag, "_done_pulses"}, done_cnt, 1);
    check_int({tag, "_err"}, int'(err), 0);
    check_int({tag, "_max_rd_gap"}, max_gap, gap);
  endtask

  task automatic test_single_channel();
    bit to;
    fill_mem(0); set_exp(0); reset_stats();
    do_run(1, 1'b1, 1000, to);
    check_int("t1_timeout", int'(to), 0);
    check_single("t1", 0);
  endtask

  task automatic test_multi_channel();
    bit to;
    fill_mem(1); set_exp(1); reset_stats();
    do_run(3, 1'b0, 2000, to);
    check_int("t2_timeout", int'(to), 0);
    check_int("t2_rd_cnt", rd_cnt, 3 * IN_PER_CH);
    check_int("t2_rd_addr_bad", rd_bad, 0);
    check_int("t2_pool_rst_pulses", prst_pulses, 3);
    check_int("t2_wr_cnt", wr_cnt, 3 * OUT_PER_CH);
    check_int("t2_wr_bad", wr_bad, 0);
  endtask

  task automatic test_hold();
    bit to;
    fill_mem(0); set_exp(0); reset_stats();
    fork
      do_run(1, 1'b0, 1000, to);
      hold_pulse();
    join
    check_int("t3_timeout", int'(to), 0);
    check_single("t3", 10);
  endtask

  task automatic test_zero_channels();
    bit to;
    reset_stats();
    do_run(0, 1'b0, 50, to);
    check_int("t4_timeout", int'(to), 0);
    check_int("t4_busy_cycles", busy_cyc, 1);
    check_int("t4_done_pulses", done_cnt, 1);
    check_int("t4_rd_cnt", rd_cnt, 0);
    check_int("t4_wr_cnt", wr_cnt, 0);
  endtask

  task automatic test_drain_timeout();
    bit to;
    int dgap;
    fill_mem(0); set_exp(0); drop_last = 1'b1; reset_stats();
    do_run(1, 1'b0, 1000, to);
    dgap = done_cyc - last_rd_cyc;
    check_int("t5_timeout", int'(to), 0);
    check_int("t5_err", int'(err), 1);
    check_int("t5_wr_cnt", wr_cnt, OUT_PER_CH - 1);
    check_int("t5_wr_bad", wr_bad, 0);
    check_int("t5_done_pulses", done_cnt, 1);
    total++;
    if (dgap < DRAIN_MAX + 1 || dgap > DRAIN_MAX + 2) begin
      bad++;
      $display("FAIL t5_drain_length: got %0d want %0d..%0d", dgap, DRAIN_MAX + 1, DRAIN_MAX + 2);
    end
    drop_last = 1'b0; reset_stats();
    do_run(1, 1'b0, 1000, to);
    check_int("t5_rerun_err_cleared", int'(err), 0);
    check_int("t5_rerun_wr_cnt", wr_cnt, OUT_PER_CH);
  endtask

  task automatic test_reset_mid_run();
    bit to;
    int rc, wc;
    fill_mem(0); set_exp(0); reset_stats();
    @(negedge clk); start = 1'b1; num_ch = 6'd1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (rd_cnt >= 51) break;
    end
    check_int("t6_reached_read50", rd_cnt, 51);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({busy, done, err, rd_en, pool_rst, pool_valid_in, pool_pixel_in, wr_en, wr_data} !== 9'b0
        || rd_addr !== '0 || wr_addr !== '0) begin
      bad++;
      $display("FAIL t6_outputs_after_reset: got flags=%b rd=%0d wr=%0d want all 0",
               {busy, done, err, rd_en, pool_rst, pool_valid_in, pool_pixel_in, wr_en, wr_data},
               rd_addr, wr_addr);
    end
    rc = rd_cnt; wc = wr_cnt;
    repeat (5) @(negedge clk);
    #1;
    check_int("t6_no_reads_after_reset", rd_cnt - rc, 0);
    check_int("t6_no_writes_after_reset", wr_cnt - wc, 0);
    check_int("t6_idle_after_reset", int'(busy), 0);
    reset_stats();
    do_run(1, 1'b0, 1000, to);
    check_int("t6_timeout", int'(to), 0);
    check_single("t6", 0);
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_multi_channel();
    test_hold();
    test_zero_channels();
    test_drain_timeout();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
